pwm_duty_seq: RTL
=================

Name: pwm_duty_seq

Overview:
- APB4 master that plays a table of duty values into one channel compare register (CRx) of an APB4 PWM slave, one entry per PWM period.
- Period boundary comes from a trigger input, normally the PWM overflow interrupt line.
- Sits beside the PWM on the peripheral bus and sequences it without CPU involvement; software loads the table, selects the channel and starts it.

Parameters:
- TBL_DEPTH, 16, number of duty entries (power of two, 2..64)
- DATA_WIDTH, 32, width of each duty entry and of the APB data bus
- PWM_BASE, 32'h0000_0000, byte base address of the target PWM slave

Ports:
- clk_i  in  1  clock, same clock as the PWM's APB clock
- rst_n_i  in  1  asynchronous active-low reset
- start_i  in  1  single-cycle start pulse
- stop_i  in  1  single-cycle stop pulse
- loop_i  in  1  1 = wrap to entry 0 after last entry; sampled at start
- len_i  in  $clog2(TBL_DEPTH)  last entry index (entry count minus 1); sampled at start
- chn_i  in  2  target channel 0..3; sampled at start
- trg_i  in  1  period trigger, level; rising edge marks a period boundary
- tbl_we_i  in  1  table write enable
- tbl_addr_i  in  $clog2(TBL_DEPTH)  table write index
- tbl_wdata_i  in  DATA_WIDTH  table write data
- paddr_o  out  32  APB address
- psel_o  out  1  APB select
- penable_o  out  1  APB enable
- pwrite_o  out  1  APB write, always 1 while psel_o is high
- pwdata_o  out  DATA_WIDTH  APB write data
- pready_i  in  1  APB ready
- pslverr_i  in  1  APB slave error
- busy_o  out  1  sequencer not IDLE
- done_o  out  1  single-cycle pulse when a non-loop run completes or a stop completes
- err_o  out  1  sticky: pslverr seen; cleared by start
- ovr_o  out  1  sticky: trigger lost while one was already pending; cleared by start

Behaviour:
- Reset: all outputs 0, state IDLE, index 0, pending 0, trg edge register 0. The table is not reset.
- Trigger: trg_q registered each cycle; edge = trg_i & ~trg_q. An edge is accepted only while not IDLE.
- States:
  - IDLE: start_i (and not stop_i) -> latch len, loop, chn; clear err, ovr, idx, pending; go WAIT.
  - WAIT: edge or pending -> SETUP; clear pending unless a new edge arrives in the same cycle.
  - SETUP: psel=1, penable=0, paddr = PWM_BASE + 32'h10 + 4*chn, pwdata = tbl[idx]; next cycle -> ACCESS.
  - ACCESS: psel=1, penable=1, address and data held stable. Stays until pready_i.
- On pready_i in ACCESS:
  - pslverr_i = 1: err_o <= 1, go IDLE with done_o pulse.
  - stop requested: go IDLE with done_o pulse.
  - idx == len and !loop: go IDLE with done_o pulse.
  - otherwise: idx <= (idx == len) ? 0 : idx + 1, go WAIT.
- Minimum write latency is 2 cycles from SETUP entry; a trigger edge in WAIT produces SETUP on the next cycle.
- Pending: a single-deep flag set by an edge seen in SETUP or ACCESS. An edge while pending is already 1 sets ovr_o; the extra edge is dropped.
- stop_i:
  - In WAIT: go IDLE next cycle with done_o pulse.
  - In SETUP or ACCESS: set stop_req; the APB transfer always completes and is never abandoned mid-transfer.
  - start_i and stop_i together in IDLE: stop wins, nothing starts.
- start_i while busy is ignored.
- Table: register array, synchronous write, combinational read. Writes are allowed while busy; an entry written before its SETUP cycle is the value sent.
- Reset mid-transfer drops psel_o and penable_o immediately (asynchronous).
- pwdata_o is 0 whenever psel_o = 0.

Decomposition:
- Shared package pwm_seq_pkg:
  - state enum (IDLE, WAIT, SETUP, ACCESS)
  - PWM register word offsets: CTRL 0, PSCR 1, CNT 2, CMP 3, CR0..CR3 4..7, STAT 8
  - CRX byte offset constant 32'h10
- One sub-module, pwm_seq_tbl, holds the duty table (write port plus combinational read port).
- FSM, index counter, trigger edge logic and APB drive stay in the top module.

Test Plan:
- Load tbl = {10,20,30}, len=2, loop=0, chn=1, PWM_BASE=0x1000; start, then 3 trg edges with pready=1 -> three writes to 0x1014 with data 10, 20, 30; each SETUP/ACCESS is 2 cycles; done_o pulses once after the third; busy_o=0.
- Same table with loop=1 and 5 trg edges -> data sequence 10, 20, 30, 10, 20; no done_o.
- pready held low 4 cycles in ACCESS; two trg edges during the wait -> address and data stable throughout; first extra edge sets pending and its write starts right after the transfer; second extra edge sets ovr_o=1.
- pslverr=1 on the second write -> err_o=1, done_o pulse, IDLE; a fresh start clears err_o.
- stop_i asserted in ACCESS with pready delayed 3 cycles -> transfer completes, then IDLE and done_o; no further writes on later edges.
- rst_n_i low during ACCESS -> psel_o=0, busy_o=0 immediately; after release, trg edges produce no APB activity until start.

Source files
------------

// File: rtl/pwm_seq_pkg.sv
// Shared types and constants for the PWM duty-cycle sequencer.
package pwm_seq_pkg;

    // Sequencer FSM states
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_SETUP  = 2'd2,
        S_ACCESS = 2'd3
    } seq_state_e;

    // Word offsets of the target PWM slave's register map
    localparam int unsigned REG_CTRL = 0;
    localparam int unsigned REG_PSCR = 1;
    localparam int unsigned REG_CNT  = 2;
    localparam int unsigned REG_CMP  = 3;
    localparam int unsigned REG_CR0  = 4;
    localparam int unsigned REG_CR1  = 5;
    localparam int unsigned REG_CR2  = 6;
    localparam int unsigned REG_CR3  = 7;
    localparam int unsigned REG_STAT = 8;

    // Byte offset of CR0; CRx follow at 4-byte stride
    localparam logic [31:0] CRX_OFFS = 32'h10;

    // Byte address of compare register CRx for channel chn
    function automatic logic [31:0] crx_addr(input logic [31:0] base, input logic [1:0] chn);
        return base + CRX_OFFS + {28'd0, chn, 2'b00};
    endfunction

endpackage

// File: rtl/pwm_seq_tbl.sv
// Duty table: register array with one synchronous write port and one
// combinational read port. Contents are intentionally not reset.
module pwm_seq_tbl #(
    parameter int DEPTH = 16,
    parameter int DW    = 32,
    parameter int AW    = 4
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];

    // Software write port; usable while the sequencer runs
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Combinational read of the entry about to be sent
    always_comb begin
        rdata_o = mem_q[raddr_i];
    end

endmodule

// File: rtl/pwm_duty_seq.sv
// APB4 master that writes one duty-table entry per PWM period into the
// selected channel compare register of a PWM slave.
//
// APB handshake: SETUP drives psel=1/penable=0 with address and data for one
// cycle; ACCESS raises penable and holds address and data unchanged until the
// slave returns pready=1, at which point the transfer completes (pslverr is
// only meaningful in that same cycle). A started transfer is never abandoned
// except by reset.
module pwm_duty_seq
    import pwm_seq_pkg::*;
#(
    parameter int          TBL_DEPTH  = 16,
    parameter int          DATA_WIDTH = 32,
    parameter logic [31:0] PWM_BASE   = 32'h0000_0000
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic                         start_i,
    input  logic                         stop_i,
    input  logic                         loop_i,
    input  logic [$clog2(TBL_DEPTH)-1:0] len_i,
    input  logic [1:0]                   chn_i,
    input  logic                         trg_i,
    input  logic                         tbl_we_i,
    input  logic [$clog2(TBL_DEPTH)-1:0] tbl_addr_i,
    input  logic [DATA_WIDTH-1:0]        tbl_wdata_i,
    output logic [31:0]                  paddr_o,
    output logic                         psel_o,
    output logic                         penable_o,
    output logic                         pwrite_o,
    output logic [DATA_WIDTH-1:0]        pwdata_o,
    input  logic                         pready_i,
    input  logic                         pslverr_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         err_o,
    output logic                         ovr_o
);

    localparam int AW = $clog2(TBL_DEPTH);

    seq_state_e            state_q, state_d;
    logic [AW-1:0]         idx_q, idx_d;
    logic [AW-1:0]         len_q, len_d;
    logic                  loop_q, loop_d;
    logic [1:0]            chn_q, chn_d;
    logic                  pend_q, pend_d;
    logic                  stop_q, stop_d;
    logic                  err_q, err_d;
    logic                  ovr_q, ovr_d;
    logic                  done_q, done_d;
    logic                  trg_q;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] tbl_rdata;
    logic                  trg_edge;

    pwm_seq_tbl #(
        .DEPTH (TBL_DEPTH),
        .DW    (DATA_WIDTH),
        .AW    (AW)
    ) u_tbl (
        .clk_i   (clk_i),
        .we_i    (tbl_we_i),
        .waddr_i (tbl_addr_i),
        .wdata_i (tbl_wdata_i),
        .raddr_i (idx_q),
        .rdata_o (tbl_rdata)
    );

    // State and control registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            loop_q  <= 1'b0;
            chn_q   <= 2'd0;
            pend_q  <= 1'b0;
            stop_q  <= 1'b0;
            err_q   <= 1'b0;
            ovr_q   <= 1'b0;
            done_q  <= 1'b0;
            trg_q   <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            loop_q  <= loop_d;
            chn_q   <= chn_d;
            pend_q  <= pend_d;
            stop_q  <= stop_d;
            err_q   <= err_d;
            ovr_q   <= ovr_d;
            done_q  <= done_d;
            trg_q   <= trg_i;
            wdata_q <= wdata_d;
        end
    end

    // Next-state logic: trigger bookkeeping, index advance, run control
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        len_d    = len_q;
        loop_d   = loop_q;
        chn_d    = chn_q;
        pend_d   = pend_q;
        stop_d   = stop_q;
        err_d    = err_q;
        ovr_d    = ovr_q;
        done_d   = 1'b0;
        wdata_d  = wdata_q;
        trg_edge = trg_i & ~trg_q & (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                // stop beats start when both arrive together
                if (start_i && !stop_i) begin
                    state_d = S_WAIT;
                    len_d   = len_i;
                    loop_d  = loop_i;
                    chn_d   = chn_i;
                    err_d   = 1'b0;
                    ovr_d   = 1'b0;
                    idx_d   = '0;
                    pend_d  = 1'b0;
                    stop_d  = 1'b0;
                end
            end
            S_WAIT: begin
                if (stop_i) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else if (trg_edge || pend_q) begin
                    state_d = S_SETUP;
                    // a fresh edge arriving while a pending one is consumed stays pending
                    pend_d  = pend_q & trg_edge;
                end
            end
            S_SETUP: begin
                state_d = S_ACCESS;
                wdata_d = tbl_rdata;
                if (stop_i) stop_d = 1'b1;
                if (trg_edge) begin
                    if (pend_q) ovr_d = 1'b1;
                    else        pend_d = 1'b1;
                end
            end
            S_ACCESS: begin
                if (stop_i) stop_d = 1'b1;
                if (trg_edge) begin
                    if (pend_q) ovr_d = 1'b1;
                    else        pend_d = 1'b1;
                end
                if (pready_i) begin
                    if (pslverr_i) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else if (stop_q || stop_i) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else if ((idx_q == len_q) && !loop_q) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d   = (idx_q == len_q) ? '0 : idx_q + 1'b1;
                        state_d = S_WAIT;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // APB drive and status outputs; data comes live from the table in SETUP
    // and from the captured copy in ACCESS so a table write cannot disturb it
    always_comb begin
        psel_o    = (state_q == S_SETUP) || (state_q == S_ACCESS);
        penable_o = (state_q == S_ACCESS);
        pwrite_o  = psel_o;
        paddr_o   = psel_o ? crx_addr(PWM_BASE, chn_q) : 32'd0;
        pwdata_o  = '0;
        if (state_q == S_SETUP)  pwdata_o = tbl_rdata;
        if (state_q == S_ACCESS) pwdata_o = wdata_q;
        busy_o    = (state_q != S_IDLE);
        done_o    = done_q;
        err_o     = err_q;
        ovr_o     = ovr_q;
    end

endmodule
